// File: rtl/t07_pkg.sv
// Shared types and funct3 encodings for the t07 data-memory stage.
package t07_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned encodings only exist for loads; stores treat them as word.
    function automatic acc_size_t decode_size(input logic [2:0] f3, input logic is_load);
        acc_size_t sz;
        sz = SZ_W;
        if (f3 == F3_B || (is_load && f3 == F3_BU)) begin
            sz = SZ_B;
        end else if (f3 == F3_H || (is_load && f3 == F3_HU)) begin
            sz = SZ_H;
        end else if (f3 == F3_W) begin
            sz = SZ_W;
        end
        return sz;
    endfunction

endpackage

// File: rtl/t07_byte_lane.sv
// Byte-lane steering: lane enables, store replication, load extension and
// alignment check for one access.
module t07_byte_lane
    import t07_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    acc_size_t   sz;
    logic        signed_ld;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        sz         = decode_size(funct3, is_load);
        signed_ld  = (funct3 == F3_B) || (funct3 == F3_H);
        lane_byte  = rdata[{addr_lo, 3'b000} +: 8];
        lane_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sel        = '0;
        wdata      = '0;
        load_data  = '0;
        misaligned = 1'b0;
        case (sz)
            SZ_B: begin
                sel       = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{signed_ld & lane_byte[7]}}, lane_byte};
            end
            SZ_H: begin
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{signed_ld & lane_half[15]}}, lane_half};
            end
            default: begin
                misaligned = |addr_lo;
                sel        = 4'b1111;
                wdata      = store_data;
                load_data  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/t07_mem_handler.sv
// Data-memory stage: runs one req/ack bus transaction per load/store, stalls
// the pipeline while it is outstanding and drives the writeback mux.
module t07_mem_handler
    import t07_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] storeData,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] regData,
    output logic              freeze,
    output logic              misaligned,
    output logic              bus_err
);

    localparam int unsigned      CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [3:0]        sel_q, sel_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              freeze_c, misaligned_c;

    logic              lane_is_load;
    logic [2:0]        lane_f3;
    logic [1:0]        lane_lo;
    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata, lane_load;
    logic              lane_mis;

    // One lane decoder serves both phases: live inputs while idle, latched
    // access attributes while waiting for the read data.
    assign lane_is_load = (state_q == IDLE) ? memRead : ~we_q;
    assign lane_f3      = (state_q == IDLE) ? funct3 : f3_q;
    assign lane_lo      = (state_q == IDLE) ? ALUResult[1:0] : lo_q;

    t07_byte_lane u_lane (
        .is_load    (lane_is_load),
        .funct3     (lane_f3),
        .addr_lo    (lane_lo),
        .store_data (storeData),
        .rdata      (bus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_mis)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        load_d       = load_q;
        sel_d        = sel_q;
        f3_d         = f3_q;
        lo_d         = lo_q;
        we_d         = we_q;
        err_d        = 1'b0;
        freeze_c     = 1'b0;
        misaligned_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (memRead || memWrite) begin
                    if (lane_mis) begin
                        misaligned_c = 1'b1;
                    end else begin
                        freeze_c = 1'b1;
                        addr_d   = {ALUResult[DATA_W-1:2], 2'b00};
                        sel_d    = lane_sel;
                        wdata_d  = lane_wdata;
                        we_d     = ~memRead;
                        f3_d     = funct3;
                        lo_d     = ALUResult[1:0];
                        cnt_d    = '0;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                freeze_c = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (bus_ack) begin
                    if (!we_q) begin
                        load_d = lane_load;
                    end
                    state_d = DONE;
                end else if (TIMEOUT != 0 && cnt_d == TO_VAL) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        load_d = '0;
                    end
                    state_d = DONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            sel_q   <= sel_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign bus_req    = (state_q == REQ);
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_sel    = sel_q;
    assign bus_err    = err_q;
    assign regData    = memToReg ? load_q : ALUResult;
    // Reset must silence the combinational handshake outputs immediately.
    assign freeze     = nrst & freeze_c;
    assign misaligned = nrst & misaligned_c;

endmodule
